// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin owner of a shared open-drain I2C bus with tBUF guard time.
// Optional hang watchdog with per-master lockout when I2C_ARBITER_WATCHDOG_EN is defined.
module i2c_bus_arbiter #(
  parameter int NUM_REQUESTERS  = 2,
  parameter int BUS_FREE_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  output logic [NUM_REQUESTERS-1:0] grant,
  input  logic [NUM_REQUESTERS-1:0] scl_out_req,
  input  logic [NUM_REQUESTERS-1:0] sda_out_req,
  input  logic                      scl_input,
  input  logic                      sda_input,
  output logic                      scl_output,
  output logic                      sda_output,
  output logic                      busy,
  output logic                      timeout
);
  localparam int N = NUM_REQUESTERS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int CMAX = BUS_FREE_CYCLES > TIMEOUT_CYCLES ? BUS_FREE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FREE_LAST = CW'(BUS_FREE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;
  state_t state, state_n;
  logic [N-1:0] grant_n, lockout, elig;
  logic [IW-1:0] last_owner, last_n, cand, pick;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic found;
`ifdef I2C_ARBITER_WATCHDOG_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [N-1:0] lockout_n;
  logic timeout_n;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lockout <= '0;
      timeout <= 1'b0;
    end else begin
      lockout <= lockout_n;
      timeout <= timeout_n;
    end
  end
`else
  assign lockout = '0;
  assign timeout = 1'b0;
`endif
  assign elig = request & ~lockout;
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign scl_output = &(scl_out_req | ~grant);
  assign sda_output = &(sda_out_req | ~grant);
  assign busy = state != IDLE;
  // Scan from furthest to nearest so the first eligible index after last_owner wins
  always_comb begin
    found = 1'b0;
    pick = last_owner;
    cand = last_owner;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_owner) + k) % N);
      if (elig[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n = last_owner;
    cnt_n = cnt;
`ifdef I2C_ARBITER_WATCHDOG_EN
    lockout_n = lockout & request;
    timeout_n = 1'b0;
`endif
    case (state)
      IDLE: if (found) begin
        state_n = GRANT;
        grant_n = N'(1) << pick;
        last_n = pick;
        cnt_n = '0;
      end
      GRANT: begin
        if (!request[last_owner]) begin
          grant_n = '0;
          cnt_n = '0;
          state_n = GUARD;
        end
`ifdef I2C_ARBITER_WATCHDOG_EN
        else if (cnt == TO_LAST) begin
          grant_n = '0;
          cnt_n = '0;
          state_n = GUARD;
          timeout_n = 1'b1;
          lockout_n[last_owner] = 1'b1;
        end else cnt_n = cnt_inc;
`endif
      end
      GUARD: begin
        cnt_n = (scl_input & sda_input) ? ((cnt == FREE_LAST) ? '0 : cnt_inc) : '0;
        state_n = (scl_input & sda_input & (cnt == FREE_LAST)) ? IDLE : GUARD;
      end
      default: state_n = GUARD;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= GUARD;
      grant <= '0;
      last_owner <= IW'(N - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_owner <= last_n;
      cnt <= cnt_n;
    end
  end
endmodule
